// File: rtl/seq_control_unit.sv
`default_nettype none
//============================================================================
// Module   : seq_control_unit
// Purpose  : Multi-cycle sequencer for a small accumulator datapath. Walks
//            IDLE -> FETCH -> DECODE -> EX1..EX3 per instruction, issuing
//            the datapath strobes for each phase. HALT is entered on the
//            HALT opcode or on an illegal instruction, and is left again
//            when resume_i is asserted.
// Ports    : clk_i        - clock, rising edge
//            rst_i        - synchronous reset, active low
//            instr_i      - {opcode[3:0], operand[OPR_W-1:0]}
//            alu_sign_i   - ALU negative flag (JUMP_NEG condition)
//            alu_zero_i   - ALU zero flag (JUMP_ZERO condition)
//            mem_ready_i  - data memory ready (ends LOAD/STORE waits)
//            resume_i     - leave HALT
//            pc_en .. dm_write - single-bit datapath strobes
//            register_en  - [NREG+1-k] loads reg k, [1] ALU X, [0] ALU Y
//            MUX1_ctl     - [NREG-k] selects reg k, [0] selects ALU result
//            Jump_addr    - jump target (operand)
//            DM_addr      - data-memory address (operand)
//            halted_o     - high while in HALT
//            illegal_o    - sticky illegal-instruction flag
//            state_o      - current state code
// Revision : 1.0 - initial release
//============================================================================
module seq_control_unit #(
    parameter int OPR_W = 4,
    parameter int NREG  = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [OPR_W+3:0]   instr_i,
    input  logic               alu_sign_i,
    input  logic               alu_zero_i,
    input  logic               mem_ready_i,
    input  logic               resume_i,
    output logic               pc_en,
    output logic               im_read,
    output logic               ir_en,
    output logic               mux0_ctl,
    output logic               ou_read,
    output logic               ou_write,
    output logic               alu_add,
    output logic               alu_sub,
    output logic               dm_read,
    output logic               dm_write,
    output logic [NREG+1:0]    register_en,
    output logic [NREG:0]      MUX1_ctl,
    output logic [OPR_W-1:0]   Jump_addr,
    output logic [OPR_W-1:0]   DM_addr,
    output logic               halted_o,
    output logic               illegal_o,
    output logic [2:0]         state_o
);

    localparam int HALF = OPR_W / 2;

    localparam logic [3:0] c_OP_NOP       = 4'b0000;
    localparam logic [3:0] c_OP_LOAD_B    = 4'b0001;
    localparam logic [3:0] c_OP_LOAD_A    = 4'b0010;
    localparam logic [3:0] c_OP_STORE_A   = 4'b0100;
    localparam logic [3:0] c_OP_ADD       = 4'b1000;
    localparam logic [3:0] c_OP_SUB       = 4'b1001;
    localparam logic [3:0] c_OP_JUMP      = 4'b1100;
    localparam logic [3:0] c_OP_JUMP_NEG  = 4'b1101;
    localparam logic [3:0] c_OP_JUMP_ZERO = 4'b1110;
    localparam logic [3:0] c_OP_HALT      = 4'b1111;

    localparam logic [HALF:0] c_NREG = (HALF+1)'(NREG);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EX1    = 3'd3,
        S_EX2    = 3'd4,
        S_EX3    = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t r_state;
    logic   r_illegal;

    // ------------------------------------------------------------------
    // Instruction decode (instr_i is held stable by the datapath's IR)
    // ------------------------------------------------------------------
    logic [3:0]       w_opcode;
    logic [OPR_W-1:0] w_operand;
    logic [HALF-1:0]  w_x;
    logic [HALF-1:0]  w_y;
    logic w_is_load_a, w_is_load_b, w_is_load, w_is_store;
    logic w_is_add, w_is_sub, w_is_arith, w_idx_ok;
    logic w_is_jump, w_is_jneg, w_is_jzero, w_is_nop, w_is_halt;
    logic w_known, w_illegal, w_take_jump;

    assign w_opcode  = instr_i[OPR_W+3:OPR_W];
    assign w_operand = instr_i[OPR_W-1:0];
    assign w_x       = w_operand[OPR_W-1:HALF];
    assign w_y       = w_operand[HALF-1:0];

    assign w_is_load_a = (w_opcode == c_OP_LOAD_A);
    assign w_is_load_b = (w_opcode == c_OP_LOAD_B);
    assign w_is_load   = w_is_load_a | w_is_load_b;
    assign w_is_store  = (w_opcode == c_OP_STORE_A);
    assign w_is_add    = (w_opcode == c_OP_ADD);
    assign w_is_sub    = (w_opcode == c_OP_SUB);
    assign w_is_jump   = (w_opcode == c_OP_JUMP);
    assign w_is_jneg   = (w_opcode == c_OP_JUMP_NEG);
    assign w_is_jzero  = (w_opcode == c_OP_JUMP_ZERO);
    assign w_is_nop    = (w_opcode == c_OP_NOP);
    assign w_is_halt   = (w_opcode == c_OP_HALT);

    // Register indices beyond the implemented file make ADD/SUB illegal,
    // so arithmetic strobes are only ever issued for a valid pair.
    assign w_idx_ok   = ({1'b0, w_x} < c_NREG) && ({1'b0, w_y} < c_NREG);
    assign w_is_arith = (w_is_add | w_is_sub) & w_idx_ok;

    assign w_known   = w_is_load | w_is_store | w_is_add | w_is_sub |
                       w_is_jump | w_is_jneg | w_is_jzero | w_is_nop | w_is_halt;
    assign w_illegal = ~w_known | ((w_is_add | w_is_sub) & ~w_idx_ok);

    assign w_take_jump = w_is_jump | (w_is_jneg & alu_sign_i) | (w_is_jzero & alu_zero_i);

    // One-hot MUX1 select for general register k
    function automatic logic [NREG:0] f_reg_sel(input logic [HALF-1:0] k);
        logic [NREG:0] sel;
        sel = '0;
        for (int i = 0; i < NREG; i++) begin
            if (32'(i) == 32'(k)) begin
                sel[NREG-i] = 1'b1;
            end
        end
        return sel;
    endfunction

    // ------------------------------------------------------------------
    // State register and sticky illegal flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state   <= S_IDLE;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE:   r_state <= S_FETCH;
                S_FETCH:  r_state <= S_DECODE;
                S_DECODE: r_state <= S_EX1;
                S_EX1: begin
                    if (w_illegal) begin
                        r_state   <= S_HALT;
                        r_illegal <= 1'b1;
                    end else if (w_is_halt) begin
                        r_state <= S_HALT;
                    end else if (w_is_load) begin
                        r_state <= mem_ready_i ? S_EX2 : S_EX1;
                    end else if (w_is_store | w_is_arith) begin
                        r_state <= S_EX2;
                    end else begin
                        r_state <= S_FETCH;
                    end
                end
                S_EX2: begin
                    if (w_is_arith) begin
                        r_state <= S_EX3;
                    end else if (w_is_store && !mem_ready_i) begin
                        r_state <= S_EX2;
                    end else begin
                        r_state <= S_FETCH;
                    end
                end
                S_EX3:   r_state <= S_FETCH;
                S_HALT:  r_state <= resume_i ? S_FETCH : S_HALT;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Strobes: decoded from state so nothing asserts outside its phase
    // ------------------------------------------------------------------
    always_comb begin
        pc_en       = 1'b0;
        im_read     = 1'b0;
        ir_en       = 1'b0;
        mux0_ctl    = 1'b0;
        ou_read     = 1'b0;
        ou_write    = 1'b0;
        alu_add     = 1'b0;
        alu_sub     = 1'b0;
        dm_read     = 1'b0;
        dm_write    = 1'b0;
        register_en = '0;
        MUX1_ctl    = '0;
        Jump_addr   = '0;
        DM_addr     = '0;
        halted_o    = 1'b0;
        case (r_state)
            S_FETCH: begin
                pc_en   = 1'b1;
                im_read = 1'b1;
            end
            S_DECODE: ir_en = 1'b1;
            S_EX1: begin
                if (w_is_load) begin
                    ou_read = 1'b1;
                    dm_read = 1'b1;
                    DM_addr = w_operand;
                end else if (w_is_store) begin
                    MUX1_ctl = f_reg_sel('0);
                end else if (w_is_arith) begin
                    MUX1_ctl       = f_reg_sel(w_x);
                    register_en[1] = 1'b1;
                end else if (w_take_jump) begin
                    pc_en     = 1'b1;
                    mux0_ctl  = 1'b1;
                    Jump_addr = w_operand;
                end
            end
            S_EX2: begin
                if (w_is_load) begin
                    ou_read = 1'b1;
                    dm_read = 1'b1;
                    DM_addr = w_operand;
                    // A is register 0, B is register 1
                    if (w_is_load_a) begin
                        register_en[NREG+1] = 1'b1;
                    end else begin
                        register_en[NREG] = 1'b1;
                    end
                end else if (w_is_store) begin
                    MUX1_ctl = f_reg_sel('0);
                    ou_write = 1'b1;
                    dm_write = 1'b1;
                    DM_addr  = w_operand;
                end else if (w_is_arith) begin
                    MUX1_ctl       = f_reg_sel(w_y);
                    register_en[0] = 1'b1;
                    alu_add        = w_is_add;
                    alu_sub        = w_is_sub;
                end
            end
            S_EX3: begin
                if (w_is_arith) begin
                    MUX1_ctl[0]         = 1'b1;
                    register_en[NREG+1] = 1'b1;
                end
            end
            S_HALT:  halted_o = 1'b1;
            default: ;
        endcase
    end

    assign illegal_o = r_illegal;
    assign state_o   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_seq_control_unit.sv
`default_nettype none
//============================================================================
// Module   : tb_seq_control_unit
// Purpose  : Self-checking bench for seq_control_unit (defaults OPR_W=4,
//            NREG=4). Each instruction is expanded into its expected
//            per-cycle trace from the instruction-set behaviour and compared
//            with the DUT outputs cycle by cycle.
// Revision : 1.0 - initial release
//============================================================================
module tb_seq_control_unit;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic [7:0] instr_i = 8'h00;
    logic       alu_sign_i = 1'b0;
    logic       alu_zero_i = 1'b0;
    logic       mem_ready_i = 1'b0;
    logic       resume_i = 1'b0;
    logic       pc_en, im_read, ir_en, mux0_ctl, ou_read, ou_write;
    logic       alu_add, alu_sub, dm_read, dm_write;
    logic [5:0] register_en;
    logic [4:0] MUX1_ctl;
    logic [3:0] Jump_addr, DM_addr;
    logic       halted_o, illegal_o;
    logic [2:0] state_o;

    seq_control_unit #(.OPR_W(4), .NREG(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_i),
        .alu_sign_i(alu_sign_i), .alu_zero_i(alu_zero_i),
        .mem_ready_i(mem_ready_i), .resume_i(resume_i),
        .pc_en(pc_en), .im_read(im_read), .ir_en(ir_en), .mux0_ctl(mux0_ctl),
        .ou_read(ou_read), .ou_write(ou_write), .alu_add(alu_add),
        .alu_sub(alu_sub), .dm_read(dm_read), .dm_write(dm_write),
        .register_en(register_en), .MUX1_ctl(MUX1_ctl),
        .Jump_addr(Jump_addr), .DM_addr(DM_addr),
        .halted_o(halted_o), .illegal_o(illegal_o), .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [2:0] st;
        logic       pc_en, im_read, ir_en, mux0, ou_read, ou_write;
        logic       alu_add, alu_sub, dm_read, dm_write;
        logic [5:0] reg_en;
        logic [4:0] mux1;
        logic [3:0] jaddr, dmaddr;
        logic       halted, illegal;
    } obs_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic m_illegal = 1'b0;

    // Expected view of a state with every strobe idle
    function automatic obs_t base(input logic [2:0] st);
        obs_t e;
        e = '0;
        e.st      = st;
        e.halted  = (st == 3'd6);
        e.illegal = m_illegal;
        return e;
    endfunction

    function automatic logic [4:0] reg_sel(input logic [1:0] k);
        logic [4:0] one;
        one = 5'b10000;
        return one >> k;
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1001,
            4'b1100, 4'b1101, 4'b1110, 4'b1111: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Inputs for the current cycle are already driven; check at negedge,
    // then advance to just after the next rising edge.
    task automatic cyc(input string name, input obs_t e);
        obs_t o;
        @(negedge clk_i);
        o = {state_o, pc_en, im_read, ir_en, mux0_ctl, ou_read, ou_write,
             alu_add, alu_sub, dm_read, dm_write, register_en, MUX1_ctl,
             Jump_addr, DM_addr, halted_o, illegal_o};
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL %s: instr=%h got=%h expected=%h", name, instr_i, o, e);
        end
        @(posedge clk_i);
        #1;
    endtask

    // Reset from any state; leaves the DUT in FETCH.
    task automatic do_reset();
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        m_illegal = 1'b0;
        cyc("reset_idle", base(3'd0));
        rst_i = 1'b1;
        cyc("idle_after_release", base(3'd0));
    endtask

    // Stay in HALT for n cycles, then resume; leaves the DUT in FETCH.
    task automatic halt_resume(input int n);
        for (int i = 0; i < n; i++) begin
            resume_i = 1'b0;
            cyc("halt_stay", base(3'd6));
        end
        resume_i = 1'b1;
        cyc("halt_resume", base(3'd6));
        resume_i = 1'b0;
    endtask

    // Execute one instruction starting in FETCH. Returns 1 if it ends in HALT.
    task automatic exec(input logic [7:0] instr, input int waits,
                        input logic sign, input logic zero, output logic halted);
        obs_t       e;
        logic [3:0] op;
        logic [3:0] opr;
        logic       taken;
        op  = instr[7:4];
        opr = instr[3:0];
        halted = 1'b0;
        instr_i = instr;
        alu_sign_i = sign;
        alu_zero_i = zero;
        mem_ready_i = 1'b0;
        e = base(3'd1); e.pc_en = 1'b1; e.im_read = 1'b1;
        cyc("fetch", e);
        e = base(3'd2); e.ir_en = 1'b1;
        cyc("decode", e);
        if (!is_legal(op)) begin
            cyc("ex1_illegal", base(3'd3));
            m_illegal = 1'b1;
            halted = 1'b1;
        end else if (op == 4'b0010 || op == 4'b0001) begin
            for (int i = 0; i <= waits; i++) begin
                mem_ready_i = (i == waits);
                e = base(3'd3); e.ou_read = 1'b1; e.dm_read = 1'b1; e.dmaddr = opr;
                cyc("load_ex1", e);
            end
            mem_ready_i = 1'b0;
            e = base(3'd4); e.ou_read = 1'b1; e.dm_read = 1'b1; e.dmaddr = opr;
            e.reg_en = (op == 4'b0010) ? 6'b100000 : 6'b010000;
            cyc("load_ex2", e);
        end else if (op == 4'b0100) begin
            e = base(3'd3); e.mux1 = reg_sel(2'd0);
            cyc("store_ex1", e);
            for (int i = 0; i <= waits; i++) begin
                mem_ready_i = (i == waits);
                e = base(3'd4); e.mux1 = reg_sel(2'd0); e.ou_write = 1'b1;
                e.dm_write = 1'b1; e.dmaddr = opr;
                cyc("store_ex2", e);
            end
            mem_ready_i = 1'b0;
        end else if (op == 4'b1000 || op == 4'b1001) begin
            e = base(3'd3); e.mux1 = reg_sel(opr[3:2]); e.reg_en = 6'b000010;
            cyc("arith_ex1", e);
            e = base(3'd4); e.mux1 = reg_sel(opr[1:0]); e.reg_en = 6'b000001;
            e.alu_add = (op == 4'b1000); e.alu_sub = (op == 4'b1001);
            cyc("arith_ex2", e);
            e = base(3'd5); e.mux1 = 5'b00001; e.reg_en = 6'b100000;
            cyc("arith_ex3", e);
        end else if (op[3:2] == 2'b11 && op != 4'b1111) begin
            taken = (op == 4'b1100) || (op == 4'b1101 && sign) || (op == 4'b1110 && zero);
            e = base(3'd3);
            if (taken) begin
                e.pc_en = 1'b1; e.mux0 = 1'b1; e.jaddr = opr;
            end
            cyc("jump_ex1", e);
        end else begin
            // NOP and HALT are both silent in EX1
            cyc("ex1_quiet", base(3'd3));
            halted = (op == 4'b1111);
        end
    endtask

    task automatic test_reset();
        logic h;
        instr_i = 8'h00;
        do_reset();
        exec(8'h00, 0, 1'b0, 1'b0, h);
        // Back in FETCH after a NOP
        cyc("nop_return_fetch", base(3'd1) | obs_t'({3'd0, 2'b11, 29'd0}));
    endtask

    task automatic test_load();
        logic h;
        do_reset();
        exec(8'h25, 2, 1'b0, 1'b0, h);
        exec(8'h1A, 0, 1'b0, 1'b0, h);
    endtask

    task automatic test_add();
        logic h;
        exec(8'h8B, 0, 1'b0, 1'b0, h);
        exec(8'h94, 0, 1'b0, 1'b0, h);
    endtask

    task automatic test_jump_zero();
        logic h;
        exec(8'hE7, 0, 1'b0, 1'b1, h);
        exec(8'hE7, 0, 1'b1, 1'b0, h);
        exec(8'hD3, 0, 1'b1, 1'b0, h);
        exec(8'hC9, 0, 1'b0, 1'b0, h);
    endtask

    task automatic test_illegal();
        logic h;
        exec(8'h35, 0, 1'b0, 1'b0, h);
        halt_resume(2);
        exec(8'h00, 0, 1'b0, 1'b0, h);
        exec(8'hF0, 0, 1'b0, 1'b0, h);
        // Reset taken while halted clears the sticky flag
        do_reset();
    endtask

    task automatic test_store_reset();
        obs_t e;
        logic h;
        exec(8'h49, 1, 1'b0, 1'b0, h);
        instr_i = 8'h49;
        mem_ready_i = 1'b0;
        e = base(3'd1); e.pc_en = 1'b1; e.im_read = 1'b1;
        cyc("fetch", e);
        e = base(3'd2); e.ir_en = 1'b1;
        cyc("decode", e);
        e = base(3'd3); e.mux1 = reg_sel(2'd0);
        cyc("store_ex1", e);
        e = base(3'd4); e.mux1 = reg_sel(2'd0); e.ou_write = 1'b1;
        e.dm_write = 1'b1; e.dmaddr = 4'h9;
        cyc("store_ex2_wait", e);
        // Reset wins over a ready memory in the same cycle
        rst_i = 1'b0;
        mem_ready_i = 1'b1;
        cyc("store_ex2_rst", e);
        mem_ready_i = 1'b0;
        m_illegal = 1'b0;
        cyc("store_rst_idle", base(3'd0));
        rst_i = 1'b1;
        cyc("idle_after_release", base(3'd0));
    endtask

    task automatic test_back_to_back();
        logic [7:0] instr;
        logic       h;
        for (int n = 0; n < 60; n++) begin
            instr = 8'($urandom_range(0, 255));
            exec(instr, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), h);
            if (h) begin
                halt_resume(int'($urandom_range(0, 2)));
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_add();
        test_jump_zero();
        test_illegal();
        test_store_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_control_unit.md
SEQ_CONTROL_UNIT -- requirements
Module: seq_control_unit

Interface
REQ-001 SHALL have parameter OPR_W, default 4, meaning operand field width (even, >=2); instr_i width is 4+OPR_W.
REQ-002 SHALL have parameter NREG, default 4, meaning general register count (2..2^(OPR_W/2)); register 0 is A, register 1 is B.
REQ-003 SHALL have ports: clk_i input 1, sole clock, rising edge; rst_i input 1, synchronous active-low reset.
REQ-004 SHALL have ports: instr_i input 4+OPR_W, opcode [OPR_W+3:OPR_W], operand [OPR_W-1:0]; alu_sign_i input 1, ALU negative flag; alu_zero_i input 1, ALU zero flag; mem_ready_i input 1, data-memory ready; resume_i input 1, leave HALT.
REQ-005 SHALL have ports: pc_en, im_read, ir_en, mux0_ctl, ou_read, ou_write, alu_add, alu_sub, dm_read, dm_write, each output 1, same meanings as existing datapath strobes.
REQ-006 SHALL have ports: register_en output NREG+2, [NREG+1-k] loads register k, [1] ALU operand-X latch, [0] ALU operand-Y latch.
REQ-007 SHALL have ports: MUX1_ctl output NREG+1, [NREG-k] one-hot selects register k, [0] selects ALU result.
REQ-008 SHALL have ports: Jump_addr output OPR_W; DM_addr output OPR_W; halted_o output 1; illegal_o output 1, sticky illegal-opcode flag; state_o output 3, current state code.

Function
REQ-009 SHALL implement states IDLE=0, FETCH=1, DECODE=2, EX1=3, EX2=4, EX3=5, HALT=6; state register updates on rising clk_i; outputs combinational from state, instr_i, flags; unlisted outputs 0.
REQ-010 SHALL decode opcodes NOP 0000, LOAD_B 0001, LOAD_A 0010, STORE_A 0100, ADD 1000, SUB 1001, JUMP 1100, JUMP_NEG 1101, JUMP_ZERO 1110, HALT 1111; all others illegal.
REQ-011 IDLE: all outputs 0; next FETCH.
REQ-012 FETCH: pc_en=1, im_read=1; next DECODE. DECODE: ir_en=1; next EX1.
REQ-013 EX1 LOAD_A/LOAD_B: ou_read=1, dm_read=1, DM_addr=operand; stay in EX1 while mem_ready_i=0, EX2 when 1.
REQ-014 EX2 LOAD_A/LOAD_B: ou_read, dm_read, DM_addr held; register_en loads A (LOAD_A) or B (LOAD_B); next FETCH.
REQ-015 EX1 STORE_A: MUX1_ctl selects A; next EX2. EX2 STORE_A: MUX1_ctl selects A, ou_write=1, dm_write=1, DM_addr=operand; stay while mem_ready_i=0, FETCH when 1.
REQ-016 ADD/SUB, X=operand[OPR_W-1:OPR_W/2], Y=operand[OPR_W/2-1:0]: EX1 MUX1_ctl selects X, register_en[1]=1, next EX2; EX2 MUX1_ctl selects Y, register_en[0]=1, alu_add (ADD) or alu_sub (SUB)=1, next EX3; EX3 MUX1_ctl[0]=1, register_en loads A, next FETCH.
REQ-017 Index X or Y >= NREG SHALL be treated as illegal opcode.
REQ-018 EX1 JUMP: pc_en=1, mux0_ctl=1, Jump_addr=operand; next FETCH.
REQ-019 EX1 JUMP_NEG/JUMP_ZERO: behave as JUMP when alu_sign_i / alu_zero_i =1 in that cycle, else all outputs 0; next FETCH either way.
REQ-020 EX1 NOP: outputs 0; next FETCH. EX1 HALT: next HALT.
REQ-021 EX1 illegal: illegal_o set, next HALT; illegal_o remains 1 until reset.
REQ-022 HALT: all strobes 0, halted_o=1; resume_i=1 -> FETCH next, else stay.
REQ-023 Latency from FETCH entry to next FETCH: NOP/jump 3 cycles, LOAD/STORE 4+wait cycles, ADD/SUB 5 cycles.
REQ-024 Outputs SHALL be glitch-free relative to state: no strobe asserted outside its listed state.

Reset
REQ-025 rst_i=0 at rising edge SHALL force IDLE and clear illegal_o, from any state including mid-wait and HALT; reset has priority over resume_i and mem_ready_i.
REQ-026 While in IDLE after reset all outputs SHALL be 0 and state_o=0.

Verification
REQ-027 Reset release, instr_i=0x00 -> state_o 0,1,2,3,1; only pc_en/im_read in FETCH, ir_en in DECODE.
REQ-028 LOAD_A 0x25, mem_ready_i low 2 cycles -> dm_read=1, DM_addr=5 for 3 EX1 cycles, then EX2 register_en=100000, back to FETCH.
REQ-029 ADD 0x8B (X=2,Y=3) -> EX1 MUX1_ctl=00100, register_en=000010; EX2 MUX1_ctl=00010, register_en=000001, alu_add=1; EX3 MUX1_ctl=00001, register_en=100000.
REQ-030 JUMP_ZERO 0xE7 with alu_zero_i=1 -> pc_en=1, mux0_ctl=1, Jump_addr=7; with alu_zero_i=0 -> no strobes, FETCH.
REQ-031 Opcode 0x3x -> illegal_o=1, halted_o=1; resume_i pulse -> FETCH, illegal_o stays 1; rst_i=0 -> illegal_o=0.
REQ-032 STORE_A 0x49 with rst_i=0 during EX2 wait -> next cycle IDLE, dm_write=0.
